// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
//
// Multicycle multiply/divide unit that feeds the Hi/Lo registers of the MIPS
// multicycle datapath. A one-cycle start pulse launches an operation.
//   - Multiply: radix-2 Booth. Takes 32 iteration edges, or 33 for MULTU.
//   - Divide: restoring division on operand magnitudes, then a sign fix-up.
//     Takes 32 iteration edges.
// A divide with a zero divisor finishes at once. It flags div_zero and leaves
// hi/lo untouched.
//
// Optional feature: define MULTDIV_UNSIGNED_EN to add the is_unsigned input.
// is_unsigned selects MULTU/DIVU behaviour (zero extension, no sign fix-up).
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-high reset
//   mult_start   one-cycle signed multiply request
//   div_start    one-cycle signed divide request (mult_start has priority)
//   is_unsigned  (MULTDIV_UNSIGNED_EN only) run as MULTU/DIVU
//   a, b         operands (dividend / divisor); captured on the start edge
//   hi, lo       product[63:32]/[31:0], or remainder/quotient
//   busy         high while iterating
//   done         one-cycle pulse: hi/lo hold a new result
//   div_zero     one-cycle pulse together with done on divide by zero
// ---------------------------------------------------------------------------
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mult_start,
  input  logic             div_start,
`ifdef MULTDIV_UNSIGNED_EN
  input  logic             is_unsigned,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_e;

  // Counter value on the final iteration edge.
  localparam logic [CNT_W-1:0] LAST_SIGNED   = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] LAST_UNSIGNED = CNT_W'(WIDTH);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             uns_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             busy_q, done_q, div_zero_q;

  // Booth accumulator {macc, mlr, q-1}.
  // macc carries two guard bits, so no intermediate add/sub can overflow,
  // even for the most-negative operand or a 33-bit unsigned multiplicand.
  logic [WIDTH+1:0] macc_q, mcand_q;
  logic [WIDTH:0]   mlr_q;
  logic             qm1_q;

  // Restoring divider state.
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] quo_q, dvs_q;
  logic             neg_quo_q, neg_rem_q;

  logic uns_in;
`ifdef MULTDIV_UNSIGNED_EN
  assign uns_in = is_unsigned;
`else
  assign uns_in = 1'b0;
`endif

  // Operand magnitudes used when a divide is accepted.
  logic [WIDTH-1:0] a_mag, b_mag;
  assign a_mag = (!uns_in && a[WIDTH-1]) ? -a : a;
  assign b_mag = (!uns_in && b[WIDTH-1]) ? -b : b;

  // One Booth step: add or subtract the multiplicand, then shift right arithmetically.
  logic [WIDTH+1:0]           psum, macc_d;
  logic [WIDTH:0]             mlr_d;
  logic                       qm1_d;
  logic signed [2*WIDTH+3:0]  bshift;
  logic [WIDTH-1:0]           mhi, mlo;

  // NOTE: every signal written in always_comb gets a default first,
  //       so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    psum = macc_q;
    case ({mlr_q[0], qm1_q})
      2'b01:   psum = macc_q + mcand_q;
      2'b10:   psum = macc_q - mcand_q;
      default: psum = macc_q;
    endcase
    bshift = $signed({psum, mlr_q, qm1_q}) >>> 1;
    macc_d = bshift[2*WIDTH+3:WIDTH+2];
    mlr_d  = bshift[WIDTH+1:1];
    qm1_d  = bshift[0];
    // Signed: W steps, so the product low word sits one bit above mlr[0].
    // Unsigned: W+1 steps consume the whole mlr register.
    if (uns_q) begin
      mhi = {macc_d[WIDTH-2:0], mlr_d[WIDTH]};
      mlo = mlr_d[WIDTH-1:0];
    end else begin
      mhi = macc_d[WIDTH-1:0];
      mlo = mlr_d[WIDTH:1];
    end
  end

  // One restoring-division step on magnitudes.
  // The top bit of diff acts as the borrow.
  logic [WIDTH:0]   rem_sh, diff, rem_d;
  logic [WIDTH-1:0] quo_d, dhi, dlo;

  always_comb begin
    rem_sh = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, dvs_q};
    if (!diff[WIDTH]) begin
      rem_d = diff;
      quo_d = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_d = rem_sh;
      quo_d = {quo_q[WIDTH-2:0], 1'b0};
    end
    dlo = neg_quo_q ? -quo_d : quo_d;
    dhi = neg_rem_q ? -rem_d[WIDTH-1:0] : rem_d[WIDTH-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments, so every register
  //       samples values from before the edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      uns_q      <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      macc_q     <= '0;
      mcand_q    <= '0;
      mlr_q      <= '0;
      qm1_q      <= 1'b0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          state_q    <= IDLE;
          cnt_q      <= '0;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
          div_zero_q <= 1'b0;
          if (mult_start) begin
            state_q <= MULT;
            busy_q  <= 1'b1;
            uns_q   <= uns_in;
            macc_q  <= '0;
            mlr_q   <= {!uns_in && a[WIDTH-1], a};
            qm1_q   <= 1'b0;
            mcand_q <= uns_in ? {2'b00, b} : {{2{b[WIDTH-1]}}, b};
          end else if (div_start) begin
            uns_q <= uns_in;
            if (b == '0) begin
              // Straight to DONE; hi/lo keep their previous result.
              state_q    <= DONE;
              done_q     <= 1'b1;
              div_zero_q <= 1'b1;
            end else begin
              state_q   <= DIV;
              busy_q    <= 1'b1;
              rem_q     <= '0;
              quo_q     <= a_mag;
              dvs_q     <= b_mag;
              neg_quo_q <= !uns_in && (a[WIDTH-1] ^ b[WIDTH-1]);
              neg_rem_q <= !uns_in && a[WIDTH-1];
            end
          end
        end
        MULT: begin
          macc_q <= macc_d;
          mlr_q  <= mlr_d;
          qm1_q  <= qm1_d;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (cnt_q == (uns_q ? LAST_UNSIGNED : LAST_SIGNED)) begin
            hi_q    <= mhi;
            lo_q    <= mlo;
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DIV: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_SIGNED) begin
            hi_q    <= dhi;
            lo_q    <= dlo;
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mult_div_unit
//
// Scoreboard bench for mult_div_unit (default build, signed operations only).
// Driver side:
//   - Issues starts and pushes the expected result onto a queue.
//   - Each expected result carries the values, the expected latency and the
//     expected busy-cycle count, all computed with plain 64-bit arithmetic.
// Monitor side:
//   - Pops an entry on every done pulse and compares it with the outputs.
// ---------------------------------------------------------------------------
module tb_mult_div_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, mult_start, div_start;
  logic [W-1:0] a, b, hi, lo;
  logic         busy, done, div_zero;

  mult_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .mult_start (mult_start),
    .div_start  (div_start),
`ifdef MULTDIV_UNSIGNED_EN
    .is_unsigned(1'b0),
`endif
    .a          (a),
    .b          (b),
    .hi         (hi),
    .lo         (lo),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           acc;     // cycle count right after the accepting edge
    int           lat;     // edges from accept until done is visible
    int           busy_n;  // busy cycles expected before this done
    int           id;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0, failures = 0, op_id = 0;
  logic [W-1:0] model_hi = '0, model_lo = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: MIPS MULT/DIV semantics computed with 64-bit signed arithmetic.
  function automatic exp_t model(input logic m, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t   e;
    longint p, q, r;
    e.dz = 1'b0; e.lat = 32; e.busy_n = 32; e.acc = 0; e.id = 0;
    if (m) begin
      p = longint'($signed(x)) * longint'($signed(y));
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (y == '0) begin
      e.hi = model_hi; e.lo = model_lo; e.dz = 1'b1; e.lat = 0; e.busy_n = 0;
    end else begin
      q = longint'($signed(x)) / longint'($signed(y));
      r = longint'($signed(x)) % longint'($signed(y));
      e.hi = r[31:0];
      e.lo = q[31:0];
    end
    return e;
  endfunction

  // Called at a negedge while the DUT is in IDLE or DONE.
  task automatic issue(input logic m, input logic d, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    e = model(m, x, y);
    e.acc = cyc + 1;
    e.id  = op_id++;
    sb.push_back(e);
    model_hi = e.hi;
    model_lo = e.lo;
    mult_start = m; div_start = d; a = x; b = y;
    @(negedge clk);
    mult_start = 1'b0; div_start = 1'b0;
    a = $urandom; b = $urandom;  // operands must already be captured
  endtask

  // Returns at the negedge where done is high (the DONE cycle).
  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) begin
      checks++; failures++;
      $display("FAIL timeout: done not seen within 200 cycles");
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0000_0001;
      default: return W'($urandom);
    endcase
  endfunction

  // Monitor: compares each completion against the oldest scoreboard entry.
  initial begin
    int   busy_cnt;
    exp_t e;
    busy_cnt = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        busy_cnt = 0;
      end else begin
        if (busy) busy_cnt++;
        if (!done && div_zero) check("div_zero_without_done", 64'(div_zero), 64'(0));
        if (done) begin
          if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_done: no operation outstanding");
          end else begin
            e = sb.pop_front();
            check($sformatf("op%0d_hi", e.id), 64'(hi), 64'(e.hi));
            check($sformatf("op%0d_lo", e.id), 64'(lo), 64'(e.lo));
            check($sformatf("op%0d_div_zero", e.id), 64'(div_zero), 64'(e.dz));
            check($sformatf("op%0d_latency", e.id), 64'(cyc - e.acc), 64'(e.lat));
            check($sformatf("op%0d_busy_cycles", e.id), 64'(busy_cnt), 64'(e.busy_n));
          end
          busy_cnt = 0;
        end
      end
    end
  end

  initial begin
    reset = 1'b1; mult_start = 1'b0; div_start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("reset_hi", 64'(hi), 64'(0));
    check("reset_lo", 64'(lo), 64'(0));
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_div_zero", 64'(div_zero), 64'(0));
    reset = 1'b0;
    @(negedge clk);

    // Directed corner cases.
    issue(1, 0, 32'd7, 32'hFFFF_FFFD);         wait_done(); @(negedge clk);
    issue(1, 0, 32'h8000_0000, 32'h8000_0000); wait_done(); @(negedge clk);
    issue(0, 1, 32'hFFFF_FFF9, 32'd2);         wait_done(); @(negedge clk);
    issue(0, 1, 32'h8000_0000, 32'hFFFF_FFFF); wait_done(); @(negedge clk);
    issue(0, 1, 32'h0000_0692, 32'h20);        wait_done(); @(negedge clk);  // hi=0x12 lo=0x34
    issue(0, 1, 32'd5, 32'd0);                 wait_done(); @(negedge clk);
    issue(1, 1, 32'd3, 32'd4);                 wait_done(); @(negedge clk);

    // Starts while busy are ignored.
    issue(1, 0, 32'd100, 32'd200);
    repeat (5) @(negedge clk);
    mult_start = 1'b1; div_start = 1'b1; a = 32'd9; b = 32'd0;
    @(negedge clk);
    mult_start = 1'b0; div_start = 1'b0;
    repeat (3) @(negedge clk);
    div_start = 1'b1; a = 32'd50; b = 32'd3;
    @(negedge clk);
    div_start = 1'b0;
    wait_done(); @(negedge clk);

    // Back-to-back: each start lands in the DONE cycle of the previous op.
    issue(1, 0, 32'hFFFF_0001, 32'd12345); wait_done();
    issue(0, 1, 32'd1000, 32'hFFFF_FFF9);  wait_done();
    issue(0, 1, 32'd77, 32'd0);            wait_done();
    issue(1, 0, 32'd65535, 32'd65537);     wait_done(); @(negedge clk);

    // Reset on edge E+10 of a multiply.
    issue(1, 0, 32'h1234_5678, 32'h9ABC_DEF0);  // returns after edge E
    repeat (9) @(negedge clk);                  // now after edge E+9
    reset = 1'b1;
    @(negedge clk);                             // edge E+10 sampled reset
    sb.delete();
    model_hi = '0; model_lo = '0;
    reset = 1'b0;
    check("midreset_hi", 64'(hi), 64'(0));
    check("midreset_lo", 64'(lo), 64'(0));
    check("midreset_busy", 64'(busy), 64'(0));
    check("midreset_done", 64'(done), 64'(0));
    @(negedge clk);
    check("postreset_busy", 64'(busy), 64'(0));
    check("postreset_done", 64'(done), 64'(0));
    issue(1, 0, 32'd6, 32'd7); wait_done(); @(negedge clk);

    // Randomised operations with a mix of idle gaps and back-to-back starts.
    for (int k = 0; k < 40; k++) begin
      int sel;
      sel = int'($urandom_range(0, 3));
      issue(sel != 2, sel >= 2, pick(), pick());
      wait_done();
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
